// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Brief    : EX/MEM/WB destination tracking, operand forwarding selects,
//            load-use stall with bubble injection, saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_uses_rt,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0]        c_FWD_ID  = 2'b00;
    localparam logic [1:0]        c_FWD_MEM = 2'b10;
    localparam logic [1:0]        c_FWD_WB  = 2'b01;
    localparam logic [REG_AW-1:0] c_R0      = '0;

    logic [REG_AW-1:0] r_ex_rs_q, r_ex_rt_q, r_ex_rd_q, r_mem_rd_q, r_wb_rd_q;
    logic              r_ex_rw_q, r_ex_mr_q, r_mem_rw_q, r_wb_rw_q;
    logic [CNT_W-1:0]  r_stall_count_q;

    logic [REG_AW-1:0] w_ex_rs_d, w_ex_rt_d, w_ex_rd_d;
    logic              w_ex_rw_d, w_ex_mr_d;
    logic [CNT_W-1:0]  w_stall_count_d;
    logic              w_haz, w_stall, w_bubble;
    logic [1:0]        w_fwd_a, w_fwd_b;

    // EX/MEM is checked first so the most recent producer wins.
    function automatic logic [1:0] f_fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              mem_rw,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_rw,
        input logic [REG_AW-1:0] wb_rd
    );
        if (mem_rw && (mem_rd != c_R0) && (mem_rd == src))
            return c_FWD_MEM;
        else if (wb_rw && (wb_rd != c_R0) && (wb_rd == src))
            return c_FWD_WB;
        else
            return c_FWD_ID;
    endfunction

    always_comb begin
        w_haz = id_valid && r_ex_mr_q && r_ex_rw_q && (r_ex_rd_q != c_R0) &&
                ((r_ex_rd_q == id_rs) || (id_uses_rt && (r_ex_rd_q == id_rt)));
        // A flushed instruction is dead, so there is nothing to wait for.
        w_stall  = w_haz && !flush;
        w_bubble = w_stall || flush || !id_valid;

        w_ex_rs_d = w_bubble ? c_R0 : id_rs;
        w_ex_rt_d = w_bubble ? c_R0 : id_rt;
        w_ex_rd_d = w_bubble ? c_R0 : id_rd;
        w_ex_rw_d = w_bubble ? 1'b0 : id_regwrite;
        w_ex_mr_d = w_bubble ? 1'b0 : id_memread;

        w_stall_count_d = r_stall_count_q;
        if (w_stall && (r_stall_count_q != {CNT_W{1'b1}}))
            w_stall_count_d = r_stall_count_q + 1'b1;

        w_fwd_a = f_fwd_sel(r_ex_rs_q, r_mem_rw_q, r_mem_rd_q, r_wb_rw_q, r_wb_rd_q);
        w_fwd_b = f_fwd_sel(r_ex_rt_q, r_mem_rw_q, r_mem_rd_q, r_wb_rw_q, r_wb_rd_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_rs_q       <= '0;
            r_ex_rt_q       <= '0;
            r_ex_rd_q       <= '0;
            r_ex_rw_q       <= 1'b0;
            r_ex_mr_q       <= 1'b0;
            r_mem_rd_q      <= '0;
            r_mem_rw_q      <= 1'b0;
            r_wb_rd_q       <= '0;
            r_wb_rw_q       <= 1'b0;
            r_stall_count_q <= '0;
        end else begin
            r_ex_rs_q       <= w_ex_rs_d;
            r_ex_rt_q       <= w_ex_rt_d;
            r_ex_rd_q       <= w_ex_rd_d;
            r_ex_rw_q       <= w_ex_rw_d;
            r_ex_mr_q       <= w_ex_mr_d;
            r_mem_rd_q      <= r_ex_rd_q;
            r_mem_rw_q      <= r_ex_rw_q;
            r_wb_rd_q       <= r_mem_rd_q;
            r_wb_rw_q       <= r_mem_rw_q;
            r_stall_count_q <= w_stall_count_d;
        end
    end

    assign fwd_a       = w_fwd_a;
    assign fwd_b       = w_fwd_b;
    assign stall       = w_stall;
    assign stall_count = r_stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Brief    : Directed-vector bench for fwd_hazard_unit (16-bit and 2-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_regwrite, id_memread, id_uses_rt, flush;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [1:0] fwd_a, fwd_b, fwd_a2, fwd_b2;
    logic       stall, stall2;
    logic [15:0] stall_count;
    logic [1:0]  stall_count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(5), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_uses_rt(id_uses_rt), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall(stall), .stall_count(stall_count)
    );

    fwd_hazard_unit #(.REG_AW(5), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_uses_rt(id_uses_rt), .flush(flush), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
        .stall(stall2), .stall_count(stall_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in ID; outputs settle 1 time unit later.
    task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic ut);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_regwrite = rw; id_memread = mr; id_uses_rt = ut;
        #1;
    endtask

    task automatic drain();
        drv(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    initial begin
        flush = 1'b0;
        reset = 1'b1;
        // 1. Reset with random inputs
        repeat (2) begin
            id_valid = 1'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
            id_rd = 5'($urandom); id_regwrite = 1'($urandom);
            id_memread = 1'($urandom); id_uses_rt = 1'($urandom);
            step();
        end
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("rst_fwd_a", 32'(fwd_a), 0);
        chk("rst_fwd_b", 32'(fwd_b), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_count", 32'(stall_count), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bub_fwd", 32'({fwd_a, fwd_b, stall}), 0);
        end

        // 2. ALU chain: add r3; sub rs=3; or rt=3
        drv(1, 1, 2, 3, 1, 0, 1);
        chk("chain_stall0", 32'(stall), 0);
        step();
        drv(1, 3, 0, 6, 1, 0, 0);
        chk("chain_stall1", 32'(stall), 0);
        step();
        drv(1, 7, 3, 8, 1, 0, 1);
        chk("chain_sub_fwd_a", 32'(fwd_a), 2);
        chk("chain_sub_fwd_b", 32'(fwd_b), 0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("chain_or_fwd_a", 32'(fwd_a), 0);
        chk("chain_or_fwd_b", 32'(fwd_b), 1);
        chk("chain_stall2", 32'(stall), 0);
        drain();

        // 3. Double producer to r5
        drv(1, 0, 0, 5, 1, 0, 0);
        step();
        drv(1, 0, 0, 5, 1, 0, 0);
        step();
        drv(1, 5, 5, 9, 1, 0, 1);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("dbl_fwd_a", 32'(fwd_a), 2);
        chk("dbl_fwd_b", 32'(fwd_b), 2);
        drain();

        // 4. r0 suppression
        drv(1, 0, 0, 0, 1, 0, 0);
        step();
        drv(1, 0, 0, 10, 1, 0, 1);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("r0_fwd_a", 32'(fwd_a), 0);
        chk("r0_fwd_b", 32'(fwd_b), 0);
        step();
        chk("r0_wb_fwd", 32'({fwd_a, fwd_b}), 0);
        drain();
        drv(1, 0, 0, 0, 1, 1, 0);
        step();
        drv(1, 0, 0, 10, 1, 0, 0);
        chk("r0_load_stall", 32'(stall), 0);
        step();
        drain();

        // 5. Load-use: lw r4; add rs=4
        drv(1, 1, 0, 4, 1, 1, 0);
        step();
        drv(1, 4, 2, 11, 1, 0, 1);
        chk("lu_stall", 32'(stall), 1);
        step();
        chk("lu_stall_once", 32'(stall), 0);
        chk("lu_count", 32'(stall_count), 1);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("lu_fwd_a", 32'(fwd_a), 1);
        chk("lu_fwd_b", 32'(fwd_b), 0);
        drain();
        drv(1, 1, 0, 4, 1, 1, 0);
        step();
        drv(1, 1, 4, 11, 1, 0, 0);
        chk("lu_rt_unused", 32'(stall), 0);
        step();
        drain();

        // 6. Flush overrides stall; the killed add (rd=12) must not reach EX
        drv(1, 1, 0, 4, 1, 1, 0);
        step();
        drv(1, 4, 0, 12, 1, 0, 0);
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(stall), 0);
        step();
        flush = 1'b0;
        drv(1, 12, 4, 13, 1, 0, 1);
        chk("fl_no_stall", 32'(stall), 0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("fl_bubble_fwd_a", 32'(fwd_a), 0);
        chk("fl_wb_fwd_b", 32'(fwd_b), 1);
        chk("fl_count", 32'(stall_count), 1);
        drain();

        // Saturation: 5 more stalls; 2-bit counter stops at 3
        for (int i = 0; i < 5; i++) begin
            drv(1, 1, 0, 4, 1, 1, 0);
            step();
            drv(1, 2, 4, 14, 1, 0, 1);
            chk("sat_stall", 32'(stall2), 1);
            step();
            drv(0, 0, 0, 0, 0, 0, 0);
            chk("sat_count2", 32'(stall_count2), (i + 2 > 3) ? 3 : i + 2);
            step();
        end
        chk("sat_count16", 32'(stall_count), 6);

        // Mid-operation reset discards in-flight state
        drv(1, 1, 0, 4, 1, 1, 0);
        step();
        drv(1, 4, 0, 15, 1, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drv(1, 4, 0, 15, 1, 0, 0);
        chk("rst2_stall", 32'(stall), 0);
        chk("rst2_count", 32'(stall_count), 0);
        chk("rst2_count2", 32'(stall_count2), 0);
        drv(0, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
